// File: rtl/vault_pkg.sv
// Shared constants, loader state encoding and a saturating-counter helper
// for the vault work path.
package vault_pkg;

  localparam int VAULT_PAYLOAD_BYTES = 80;
  localparam int VAULT_WORK_W        = 640;
  localparam logic [7:0] VAULT_SOF_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    LS_HUNT    = 2'd0,
    LS_PAYLOAD = 2'd1,
    LS_CHECK   = 2'd2,
    LS_COMMIT  = 2'd3
  } loader_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vault_idle_timer.sv
// Idle down-counter: reloads on clear, counts while enabled, and pulses
// expired once LIMIT idle cycles have elapsed since the last clear. LIMIT = 0 disables it.
module vault_idle_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LOAD = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

  logic [W-1:0] rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= LOAD;
    end else if (clear) begin
      rem <= LOAD;
    end else if (enable && (rem != '0)) begin
      rem <= rem - W'(1);
    end
  end

  // clear wins so an accepted byte can never coincide with expiry
  assign expired = (LIMIT != 0) && enable && !clear && (rem == '0);

endmodule

// File: rtl/vault_work_loader.sv
// Byte-stream receiver assembling 80-byte block headers into 640-bit work
// packages. Define VAULT_WORK_CHECKSUM_EN to add a trailing checksum byte.
//
// state   | meaning
// HUNT    | discard bytes until SOF
// PAYLOAD | shift in 80 header bytes
// CHECK   | checksum byte (VAULT_WORK_CHECKSUM_EN only)
// COMMIT  | wait for free output slot, in_ready low
module vault_work_loader
  import vault_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SOF_BYTE       = VAULT_SOF_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [VAULT_WORK_W-1:0] work_package,
  output logic                    work_valid,
  input  logic                    work_ready,
  output logic [15:0]             frames_ok,
  output logic [15:0]             frames_bad
);

  localparam logic [1:0] ST_HUNT    = LS_HUNT;
  localparam logic [1:0] ST_PAYLOAD = LS_PAYLOAD;
  localparam logic [1:0] ST_CHECK   = LS_CHECK;
  localparam logic [1:0] ST_COMMIT  = LS_COMMIT;
  localparam logic [6:0] LAST_IDX   = 7'(VAULT_PAYLOAD_BYTES - 1);

  logic [1:0]              state;
  logic [6:0]              idx;
  logic [VAULT_WORK_W-1:0] asm_q;
  logic                    accept;
  logic                    timeout;

  assign in_ready = (state != ST_COMMIT);
  assign accept   = in_valid && in_ready;

  vault_idle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  ((state == ST_PAYLOAD) || (state == ST_CHECK)),
    .expired (timeout)
  );

`ifdef VAULT_WORK_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_next;
  assign sum_next = sum + in_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_HUNT;
      idx          <= '0;
      asm_q        <= '0;
      work_package <= '0;
      work_valid   <= 1'b0;
      frames_ok    <= '0;
      frames_bad   <= '0;
`ifdef VAULT_WORK_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      // a COMMIT below overrides this drop when it reloads on the same edge
      if (work_valid && work_ready) work_valid <= 1'b0;

      case (state)
        ST_HUNT: begin
          if (accept && (in_data == SOF_BYTE)) begin
            state <= ST_PAYLOAD;
            idx   <= '0;
`ifdef VAULT_WORK_CHECKSUM_EN
            sum   <= '0;
`endif
          end
        end
        ST_PAYLOAD: begin
          if (timeout) begin
            state      <= ST_HUNT;
            frames_bad <= sat_inc16(frames_bad);
          end else if (accept) begin
            // first byte ends at the top after 80 shifts
            asm_q <= {asm_q[VAULT_WORK_W-9:0], in_data};
            idx   <= idx + 7'd1;
`ifdef VAULT_WORK_CHECKSUM_EN
            sum   <= sum_next;
`endif
            if (idx == LAST_IDX) begin
`ifdef VAULT_WORK_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state <= ST_COMMIT;
`endif
            end
          end
        end
`ifdef VAULT_WORK_CHECKSUM_EN
        ST_CHECK: begin
          if (timeout) begin
            state      <= ST_HUNT;
            frames_bad <= sat_inc16(frames_bad);
          end else if (accept) begin
            if (sum_next == 8'h00) begin
              state <= ST_COMMIT;
            end else begin
              state      <= ST_HUNT;
              frames_bad <= sat_inc16(frames_bad);
            end
          end
        end
`endif
        ST_COMMIT: begin
          if (!work_valid || work_ready) begin
            work_package <= asm_q;
            work_valid   <= 1'b1;
            frames_ok    <= sat_inc16(frames_ok);
            state        <= ST_HUNT;
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

endmodule
